bcd_serial_add_ctrl: RTL and testbench

- Digit-serial sequencer for multi-digit BCD addition.
- Accepts two packed BCD operands through a valid/ready handshake.
- Time-multiplexes one single-digit BCD adder cell over DIGITS cycles, least significant digit first, with the carry held in a register between cycles.
- Returns the (4*DIGITS+4)-bit packed BCD sum through a valid/ready handshake.
- Sits between operand producers and downstream consumers, replacing a fully parallel digit-adder chain where area matters more than latency.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit_cell.sv | 21 ++
 rtl/bcd_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and nibble helpers for the digit-serial BCD adder.
package bcd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone,
      StFix
   } state_e;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'h6;

   // True when the nibble is a legal decimal digit.
   function automatic logic is_bcd(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

   // Nines complement; illegal nibbles wrap modulo 16.
   function automatic logic [3:0] nines_comp(input logic [3:0] nibble);
      return BCD_MAX - nibble;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single-digit BCD adder: binary add, then +6 correction when the digit carries.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] z;

   // Raw sum, decimal carry detect and correction.
   always_comb begin
      z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      cout = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
      s    = cout ? (z[3:0] + BCD_CORR) : z[3:0];
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one digit cell reused over DIGITS cycles,
// LSD first, with valid/ready handshakes on operands and result.
// Optional subtract support (op_sub, neg, FIX pass) is enabled by BCD_SUB_EN.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   op_a,
   input  logic [4*DIGITS-1:0]   op_b,
`ifdef BCD_SUB_EN
   input  logic                  op_sub,
   output logic                  neg,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS+3:0]   result,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e                state_q, state_d;
   logic [4*DIGITS-1:0]   a_q, a_d;
   logic [4*DIGITS-1:0]   b_q, b_d;
   logic [4*DIGITS+3:0]   result_q, result_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  carry_q, carry_d;
   logic                  err_q, err_d;
`ifdef BCD_SUB_EN
   logic                  sub_q, sub_d;
   logic                  neg_q, neg_d;
`endif

   logic [3:0] cell_a, cell_b, cell_s;
   logic       cell_cin, cell_cout;
   logic [3:0] dig_a, dig_b, dig_r;
   logic       bad_in;

   bcd_digit_cell u_cell (
      .a    (cell_a),
      .b    (cell_b),
      .cin  (cell_cin),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // Select the current digit of each operand and of the stored result.
   always_comb begin
      dig_a = 4'h0;
      dig_b = 4'h0;
      dig_r = 4'h0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            dig_a = a_q[4*i +: 4];
            dig_b = b_q[4*i +: 4];
            dig_r = result_q[4*i +: 4];
         end
      end
   end

   // Flag any non-decimal nibble on the incoming operands.
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         bad_in = bad_in | ~is_bcd(op_a[4*i +: 4]) | ~is_bcd(op_b[4*i +: 4]);
      end
   end

   // Next-state, datapath updates and digit cell input muxing.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      err_d    = err_q;
`ifdef BCD_SUB_EN
      sub_d    = sub_q;
      neg_d    = neg_q;
`endif
      cell_a   = dig_a;
      cell_b   = dig_b;
      cell_cin = carry_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = 1'b0;
               idx_d   = '0;
               err_d   = bad_in;
`ifdef BCD_SUB_EN
               sub_d   = op_sub;
               neg_d   = 1'b0;
               // Subtract as A + nines(B) + 1.
               if (op_sub) begin
                  for (int i = 0; i < int'(DIGITS); i++) begin
                     b_d[4*i +: 4] = nines_comp(op_b[4*i +: 4]);
                  end
                  carry_d = 1'b1;
               end
`endif
               state_d = StRun;
            end
         end

         StRun: begin
            carry_d = cell_cout;
            for (int i = 0; i < int'(DIGITS); i++) begin
               if (idx_q == IDX_W'(i)) result_d[4*i +: 4] = cell_s;
            end
            if (idx_q == LAST_IDX) begin
               result_d[4*DIGITS +: 4] = {3'b000, cell_cout};
               state_d = StDone;
`ifdef BCD_SUB_EN
               if (sub_q) begin
                  // Carry out marks a non-negative difference and is not a digit.
                  result_d[4*DIGITS +: 4] = 4'h0;
                  if (!cell_cout) begin
                     // Negative: magnitude is the tens complement of the stored digits.
                     neg_d   = 1'b1;
                     carry_d = 1'b1;
                     idx_d   = '0;
                     state_d = StFix;
                  end
               end
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

`ifdef BCD_SUB_EN
         StFix: begin
            // Nines complement each stored digit and ripple in the +1.
            cell_a  = nines_comp(dig_r);
            cell_b  = 4'h0;
            carry_d = cell_cout;
            for (int i = 0; i < int'(DIGITS); i++) begin
               if (idx_q == IDX_W'(i)) result_d[4*i +: 4] = cell_s;
            end
            if (idx_q == LAST_IDX) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
`endif

         StDone: begin
            if (out_ready) state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
`ifdef BCD_SUB_EN
         sub_q    <= 1'b0;
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
`ifdef BCD_SUB_EN
         sub_q    <= sub_d;
         neg_q    <= neg_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign result    = result_q;
   assign err       = err_q;
`ifdef BCD_SUB_EN
   assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=3); subtract steps need BCD_SUB_EN.
module tb_bcd_serial_add_ctrl;

   localparam int unsigned DIGITS = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [4*DIGITS-1:0] op_a;
   logic [4*DIGITS-1:0] op_b;
   logic                out_valid;
   logic                out_ready;
   logic [4*DIGITS+3:0] result;
   logic                busy;
   logic                err;
`ifdef BCD_SUB_EN
   logic                op_sub;
   logic                neg;
`endif

   int tests = 0;
   int fails = 0;
   int lat;

   bcd_serial_add_ctrl #(
      .DIGITS (DIGITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
`ifdef BCD_SUB_EN
      .op_sub    (op_sub),
      .neg       (neg),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one operand pair; returns edges from accept edge (inclusive) to out_valid.
   task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic sub,
                         output int latency);
      op_a     = a;
      op_b     = b;
`ifdef BCD_SUB_EN
      op_sub   = sub;
`endif
      in_valid = 1'b1;
      check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      latency  = 1;
      while (out_valid !== 1'b1 && latency < 40) begin
         @(posedge clk);
         #1;
         latency++;
      end
      if (sub) latency = latency + 0;
   endtask

   // Complete the result handshake.
   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_take", {31'b0, out_valid}, 32'd0);
      check("in_ready_after_take", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
`ifdef BCD_SUB_EN
      op_sub    = 1'b0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", {16'b0, result}, 32'h0000);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;

      // 999 + 999
      run_op(12'h999, 12'h999, 1'b0, lat);
      check("add999_latency", lat, 32'd4);
      check("add999_result", {16'b0, result}, 32'h1998);
      check("add999_err", {31'b0, err}, 32'd0);
      check("add999_busy", {31'b0, busy}, 32'd1);
      take();

      // Zero and full carry chain
      run_op(12'h000, 12'h000, 1'b0, lat);
      check("add000_latency", lat, 32'd4);
      check("add000_result", {16'b0, result}, 32'h0000);
      take();
      check("idle_holds_result", {16'b0, result}, 32'h0000);
      run_op(12'h001, 12'h999, 1'b0, lat);
      check("chain_result", {16'b0, result}, 32'h1000);
      check("chain_err", {31'b0, err}, 32'd0);
      take();
      check("idle_holds_result2", {16'b0, result}, 32'h1000);

      // Backpressure with an ignored in_valid pulse
      run_op(12'h999, 12'h999, 1'b0, lat);
      check("bp_latency", lat, 32'd4);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            op_a     = 12'h111;
            op_b     = 12'h222;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         check("bp_result", {16'b0, result}, 32'h1998);
         check("bp_err", {31'b0, err}, 32'd0);
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      take();
      check("bp_no_new_op_busy", {31'b0, busy}, 32'd0);
      check("bp_result_kept", {16'b0, result}, 32'h1998);

      // Reset mid-run
      op_a     = 12'h123;
      op_b     = 12'h456;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("midrun_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrun_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrun_rst_result", {16'b0, result}, 32'h0000);
      check("midrun_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrun_rst_busy", {31'b0, busy}, 32'd0);
      run_op(12'h250, 12'h250, 1'b0, lat);
      check("after_rst_latency", lat, 32'd4);
      check("after_rst_result", {16'b0, result}, 32'h0500);
      take();

      // Illegal digit
      run_op(12'h00A, 12'h000, 1'b0, lat);
      check("illegal_latency", lat, 32'd4);
      check("illegal_err", {31'b0, err}, 32'd1);
      check("illegal_result", {16'b0, result}, 32'h0010);
      take();

      // Legal operands clear err again
      run_op(12'h123, 12'h456, 1'b0, lat);
      check("legal_err_clear", {31'b0, err}, 32'd0);
      check("add123_result", {16'b0, result}, 32'h0579);
      take();

`ifdef BCD_SUB_EN
      run_op(12'h100, 12'h001, 1'b1, lat);
      check("sub_pos_latency", lat, 32'd4);
      check("sub_pos_result", {16'b0, result}, 32'h0099);
      check("sub_pos_neg", {31'b0, neg}, 32'd0);
      take();
      run_op(12'h001, 12'h100, 1'b1, lat);
      check("sub_neg_latency", lat, 32'd7);
      check("sub_neg_result", {16'b0, result}, 32'h0099);
      check("sub_neg_neg", {31'b0, neg}, 32'd1);
      take();
      run_op(12'h999, 12'h999, 1'b0, lat);
      check("add_after_sub_neg", {31'b0, neg}, 32'd0);
      check("add_after_sub_result", {16'b0, result}, 32'h1998);
      take();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
